// File: rtl/multicycle_logic_controller.sv
// rtl/multicycle_logic_controller.sv - FETCH/DECODE/EX/MEM/WB control sequencer for the 16-bit CR16-style core.
// Outputs are decoded from state and the opcode/function latched in DECODE; mem_ready gates FETCH and MEM.
module multicycle_logic_controller #(
  parameter int OPBITS       = 4,
  parameter int FUNCTBITS    = 4,
  parameter int MULT_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [OPBITS-1:0]    opcode,
  input  logic [FUNCTBITS-1:0] functionCode,
  input  logic                 mem_ready,
  output logic                 memReq,
  output logic                 irEn,
  output logic                 pcEn,
  output logic                 branch,
  output logic                 jump,
  output logic                 jumpRA,
  output logic                 raWrite,
  output logic                 CFWrite,
  output logic                 LZNWrite,
  output logic                 wbPSR,
  output logic                 RtSrcReg,
  output logic                 wbSrc,
  output logic                 memSrc,
  output logic                 shiftSrc,
  output logic                 aluSrcb,
  output logic                 shiftType,
  output logic                 regWriteEn,
  output logic                 memWrite,
  output logic [FUNCTBITS-1:0] aluop,
  output logic                 illegal,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EX     = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam int CW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

  localparam logic [OPBITS-1:0] OP_RTYPE   = OPBITS'(4'b0000);
  localparam logic [OPBITS-1:0] OP_RTYPE2  = OPBITS'(4'b1000);
  localparam logic [OPBITS-1:0] OP_MEMTYPE = OPBITS'(4'b0100);
  localparam logic [OPBITS-1:0] OP_ADDI    = OPBITS'(4'b0101);
  localparam logic [OPBITS-1:0] OP_SUBI    = OPBITS'(4'b1001);
  localparam logic [OPBITS-1:0] OP_MULTI   = OPBITS'(4'b1110);
  localparam logic [OPBITS-1:0] OP_CMPI    = OPBITS'(4'b1011);
  localparam logic [OPBITS-1:0] OP_ANDI    = OPBITS'(4'b0001);
  localparam logic [OPBITS-1:0] OP_ORI     = OPBITS'(4'b0010);
  localparam logic [OPBITS-1:0] OP_XORI    = OPBITS'(4'b0011);
  localparam logic [OPBITS-1:0] OP_BCOND   = OPBITS'(4'b1100);
  localparam logic [OPBITS-1:0] OP_JAL     = OPBITS'(4'b1111);
  localparam logic [OPBITS-1:0] OP_JRA     = OPBITS'(4'b0111);

  localparam logic [FUNCTBITS-1:0] F_ADD   = FUNCTBITS'(4'b0101);
  localparam logic [FUNCTBITS-1:0] F_ADDU  = FUNCTBITS'(4'b0110);
  localparam logic [FUNCTBITS-1:0] F_SUB   = FUNCTBITS'(4'b1001);
  localparam logic [FUNCTBITS-1:0] F_MULT  = FUNCTBITS'(4'b1110);
  localparam logic [FUNCTBITS-1:0] F_CMP   = FUNCTBITS'(4'b1011);
  localparam logic [FUNCTBITS-1:0] F_AND   = FUNCTBITS'(4'b0001);
  localparam logic [FUNCTBITS-1:0] F_OR    = FUNCTBITS'(4'b0010);
  localparam logic [FUNCTBITS-1:0] F_XOR   = FUNCTBITS'(4'b0011);
  localparam logic [FUNCTBITS-1:0] F_NOT   = FUNCTBITS'(4'b0100);
  localparam logic [FUNCTBITS-1:0] F_LSH   = FUNCTBITS'(4'b0100);
  localparam logic [FUNCTBITS-1:0] F_ASH   = FUNCTBITS'(4'b0110);
  localparam logic [FUNCTBITS-1:0] F_LOAD  = FUNCTBITS'(4'b0000);
  localparam logic [FUNCTBITS-1:0] F_STR   = FUNCTBITS'(4'b0100);
  localparam logic [FUNCTBITS-1:0] F_SCOND = FUNCTBITS'(4'b1101);
  localparam logic [FUNCTBITS-1:0] F_J     = FUNCTBITS'(4'b1100);
  localparam logic [FUNCTBITS-1:0] F_MEMADD = FUNCTBITS'(4'b0101);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [OPBITS-1:0]      r_opcode;
  logic [FUNCTBITS-1:0]   r_funct;
  logic [CW-1:0]          r_mul_cnt;

  logic w_rtype, w_rtype2, w_memtype;
  logic w_add, w_addu, w_sub, w_mult, w_cmp, w_and, w_or, w_xor, w_not, w_rt_legal;
  logic w_lsh, w_lshi, w_ash, w_ashi, w_shift;
  logic w_load, w_str, w_scond, w_j;
  logic w_addi, w_subi, w_multi, w_cmpi, w_andi, w_ori, w_xori, w_bcond, w_itype;
  logic w_jal, w_jra;
  logic w_illegal, w_mul_any, w_short, w_ex_last, w_cf, w_lzn;

  assign w_rtype   = (r_opcode == OP_RTYPE);
  assign w_rtype2  = (r_opcode == OP_RTYPE2);
  assign w_memtype = (r_opcode == OP_MEMTYPE);

  assign w_add  = w_rtype && (r_funct == F_ADD);
  assign w_addu = w_rtype && (r_funct == F_ADDU);
  assign w_sub  = w_rtype && (r_funct == F_SUB);
  assign w_mult = w_rtype && (r_funct == F_MULT);
  assign w_cmp  = w_rtype && (r_funct == F_CMP);
  assign w_and  = w_rtype && (r_funct == F_AND);
  assign w_or   = w_rtype && (r_funct == F_OR);
  assign w_xor  = w_rtype && (r_funct == F_XOR);
  assign w_not  = w_rtype && (r_funct == F_NOT);
  assign w_rt_legal = w_add | w_addu | w_sub | w_mult | w_cmp | w_and | w_or | w_xor | w_not;

  // Immediate shifts ignore funct[0]: it carries the shift direction/amount bit.
  assign w_lsh   = w_rtype2 && (r_funct == F_LSH);
  assign w_lshi  = w_rtype2 && (r_funct[3:1] == 3'b000);
  assign w_ash   = w_rtype2 && (r_funct == F_ASH);
  assign w_ashi  = w_rtype2 && (r_funct[3:1] == 3'b001);
  assign w_shift = w_lsh | w_lshi | w_ash | w_ashi;

  assign w_load  = w_memtype && (r_funct == F_LOAD);
  assign w_str   = w_memtype && (r_funct == F_STR);
  assign w_scond = w_memtype && (r_funct == F_SCOND);
  assign w_j     = w_memtype && (r_funct == F_J);

  assign w_addi  = (r_opcode == OP_ADDI);
  assign w_subi  = (r_opcode == OP_SUBI);
  assign w_multi = (r_opcode == OP_MULTI);
  assign w_cmpi  = (r_opcode == OP_CMPI);
  assign w_andi  = (r_opcode == OP_ANDI);
  assign w_ori   = (r_opcode == OP_ORI);
  assign w_xori  = (r_opcode == OP_XORI);
  assign w_bcond = (r_opcode == OP_BCOND);
  assign w_itype = w_addi | w_subi | w_multi | w_cmpi | w_andi | w_ori | w_xori | w_bcond;

  assign w_jal = (r_opcode == OP_JAL);
  assign w_jra = (r_opcode == OP_JRA);

  assign w_illegal = !(w_rt_legal | w_shift | w_load | w_str | w_scond | w_j |
                       w_itype | w_jal | w_jra);
  assign w_mul_any = w_mult | w_multi;
  assign w_short   = w_cmp | w_cmpi | w_bcond | w_j | w_jra | w_jal | w_scond;
  assign w_ex_last = !w_mul_any || (r_mul_cnt == CW'(MULT_LATENCY - 1));
  assign w_cf      = w_add | w_addi | w_sub | w_subi | w_addu;
  assign w_lzn     = w_cmp | w_cmpi | w_sub | w_subi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_funct   <= '0;
      r_mul_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
        r_funct  <= functionCode;
      end
      if ((r_state == S_EX) && w_mul_any && !w_ex_last) begin
        r_mul_cnt <= r_mul_cnt + CW'(1);
      end else begin
        r_mul_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = S_FETCH;
    memReq      = 1'b0;
    irEn        = 1'b0;
    pcEn        = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    jumpRA      = 1'b0;
    raWrite     = 1'b0;
    CFWrite     = 1'b0;
    LZNWrite    = 1'b0;
    wbPSR       = 1'b0;
    RtSrcReg    = 1'b0;
    wbSrc       = 1'b0;
    memSrc      = 1'b0;
    shiftSrc    = 1'b0;
    aluSrcb     = 1'b0;
    shiftType   = 1'b0;
    regWriteEn  = 1'b0;
    memWrite    = 1'b0;
    aluop       = '0;
    illegal     = 1'b0;

    case (r_state)
      S_FETCH: begin
        memReq = 1'b1;
        if (mem_ready) begin
          irEn        = 1'b1;
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DECODE: w_state_nxt = S_EX;
      S_EX: begin
        if (w_illegal) begin
          illegal     = 1'b1;
          pcEn        = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          if (w_rtype)              aluop = r_funct;
          else if (w_itype)         aluop = FUNCTBITS'(r_opcode);
          else if (w_load || w_str) aluop = F_MEMADD;
          aluSrcb    = w_itype;
          shiftSrc   = w_shift;
          shiftType  = w_ash | w_ashi;
          RtSrcReg   = w_lsh | w_ash;
          CFWrite    = w_cf & w_ex_last;
          LZNWrite   = w_lzn & w_ex_last;
          wbPSR      = (w_cf | w_lzn) & w_ex_last;
          branch     = w_bcond;
          jump       = w_j | w_jal;
          jumpRA     = w_jra;
          raWrite    = w_jal;
          regWriteEn = w_scond;
          pcEn       = w_short;
          if (!w_ex_last)           w_state_nxt = S_EX;
          else if (w_load || w_str) w_state_nxt = S_MEM;
          else if (w_short)         w_state_nxt = S_FETCH;
          else                      w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        memReq   = 1'b1;
        memSrc   = 1'b1;
        memWrite = w_str;
        if (!mem_ready)  w_state_nxt = S_MEM;
        else if (w_load) w_state_nxt = S_WB;
        else begin
          pcEn        = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_WB: begin
        regWriteEn  = 1'b1;
        wbSrc       = w_load;
        pcEn        = 1'b1;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase

    // Reset masks every output combinationally so a reset between edges
    // drops memReq/memWrite without waiting for the state register.
    if (!reset_n) begin
      memReq     = 1'b0;
      irEn       = 1'b0;
      pcEn       = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      jumpRA     = 1'b0;
      raWrite    = 1'b0;
      CFWrite    = 1'b0;
      LZNWrite   = 1'b0;
      wbPSR      = 1'b0;
      RtSrcReg   = 1'b0;
      wbSrc      = 1'b0;
      memSrc     = 1'b0;
      shiftSrc   = 1'b0;
      aluSrcb    = 1'b0;
      shiftType  = 1'b0;
      regWriteEn = 1'b0;
      memWrite   = 1'b0;
      aluop      = '0;
      illegal    = 1'b0;
    end
  end

  assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_logic_controller.sv
// tb/tb_multicycle_logic_controller.sv - directed scoreboard bench for multicycle_logic_controller.
// The driver queues the hand-derived expected outputs per cycle; a negedge monitor pops and compares.
module tb_multicycle_logic_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] opcode;
  logic [3:0] functionCode;
  logic       mem_ready;
  logic memReq, irEn, pcEn, branch, jump, jumpRA, raWrite, CFWrite, LZNWrite, wbPSR;
  logic RtSrcReg, wbSrc, memSrc, shiftSrc, aluSrcb, shiftType, regWriteEn, memWrite, illegal;
  logic [3:0] aluop;
  logic [2:0] state_dbg;

  multicycle_logic_controller #(.OPBITS(4), .FUNCTBITS(4), .MULT_LATENCY(3)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .functionCode(functionCode),
    .mem_ready(mem_ready), .memReq(memReq), .irEn(irEn), .pcEn(pcEn), .branch(branch),
    .jump(jump), .jumpRA(jumpRA), .raWrite(raWrite), .CFWrite(CFWrite), .LZNWrite(LZNWrite),
    .wbPSR(wbPSR), .RtSrcReg(RtSrcReg), .wbSrc(wbSrc), .memSrc(memSrc), .shiftSrc(shiftSrc),
    .aluSrcb(aluSrcb), .shiftType(shiftType), .regWriteEn(regWriteEn), .memWrite(memWrite),
    .aluop(aluop), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [18:0] M_MEMREQ  = 19'd1 << 18;
  localparam logic [18:0] M_IREN    = 19'd1 << 17;
  localparam logic [18:0] M_PCEN    = 19'd1 << 16;
  localparam logic [18:0] M_BRANCH  = 19'd1 << 15;
  localparam logic [18:0] M_JUMP    = 19'd1 << 14;
  localparam logic [18:0] M_JUMPRA  = 19'd1 << 13;
  localparam logic [18:0] M_RAWRITE = 19'd1 << 12;
  localparam logic [18:0] M_CF      = 19'd1 << 11;
  localparam logic [18:0] M_LZN     = 19'd1 << 10;
  localparam logic [18:0] M_WBPSR   = 19'd1 << 9;
  localparam logic [18:0] M_RTSRC   = 19'd1 << 8;
  localparam logic [18:0] M_WBSRC   = 19'd1 << 7;
  localparam logic [18:0] M_MEMSRC  = 19'd1 << 6;
  localparam logic [18:0] M_SHSRC   = 19'd1 << 5;
  localparam logic [18:0] M_ALUSRCB = 19'd1 << 4;
  localparam logic [18:0] M_SHTYPE  = 19'd1 << 3;
  localparam logic [18:0] M_REGWE   = 19'd1 << 2;
  localparam logic [18:0] M_MEMWR   = 19'd1 << 1;
  localparam logic [18:0] M_ILL     = 19'd1 << 0;

  logic [25:0] w_got;
  assign w_got = {state_dbg, aluop, memReq, irEn, pcEn, branch, jump, jumpRA, raWrite,
                  CFWrite, LZNWrite, wbPSR, RtSrcReg, wbSrc, memSrc, shiftSrc, aluSrcb,
                  shiftType, regWriteEn, memWrite, illegal};

  logic [25:0] q_exp[$];
  string       q_name[$];
  int          n_vec = 0;
  int          n_err = 0;

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      logic [25:0] e;
      string       nm;
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      n_vec++;
      if (w_got !== e) begin
        n_err++;
        $display("FAIL %s: got st=%0d aluop=%b ctl=%b, required st=%0d aluop=%b ctl=%b",
                 nm, w_got[25:23], w_got[22:19], w_got[18:0], e[25:23], e[22:19], e[18:0]);
      end
    end
  end

  task automatic cyc(input logic rdy, input string nm, input logic [2:0] st,
                     input logic [3:0] op, input logic [18:0] f);
    mem_ready = rdy;
    q_exp.push_back({st, op, f});
    q_name.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] op, input logic [3:0] fn);
    opcode       = op;
    functionCode = fn;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 4'h0;
    functionCode = 4'h0;
    @(posedge clk);
    #1;
    cyc(1, "reset_outputs", 3'd0, 4'h0, 19'd0);
    reset_n = 1'b1;

    // ADD: 0,1,2,4 then FETCH
    instr(4'b0000, 4'b0101);
    cyc(1, "add_fetch",  3'd0, 4'h0,    M_MEMREQ | M_IREN);
    cyc(0, "add_decode", 3'd1, 4'h0,    19'd0);
    cyc(0, "add_ex",     3'd2, 4'b0101, M_CF | M_WBPSR);
    cyc(0, "add_wb",     3'd4, 4'h0,    M_REGWE | M_PCEN);

    // MULTI with one stalled fetch; EX held 3 cycles
    instr(4'b1110, 4'b0000);
    cyc(0, "multi_fetch_wait", 3'd0, 4'h0,    M_MEMREQ);
    cyc(1, "multi_fetch",      3'd0, 4'h0,    M_MEMREQ | M_IREN);
    cyc(0, "multi_decode",     3'd1, 4'h0,    19'd0);
    cyc(0, "multi_ex1",        3'd2, 4'b1110, M_ALUSRCB);
    cyc(0, "multi_ex2",        3'd2, 4'b1110, M_ALUSRCB);
    cyc(0, "multi_ex3",        3'd2, 4'b1110, M_ALUSRCB);
    cyc(0, "multi_wb",         3'd4, 4'h0,    M_REGWE | M_PCEN);

    // LOAD with two MEM wait cycles
    instr(4'b0100, 4'b0000);
    cyc(1, "load_fetch",  3'd0, 4'h0,    M_MEMREQ | M_IREN);
    cyc(0, "load_decode", 3'd1, 4'h0,    19'd0);
    cyc(0, "load_ex",     3'd2, 4'b0101, 19'd0);
    cyc(0, "load_mem1",   3'd3, 4'h0,    M_MEMREQ | M_MEMSRC);
    cyc(0, "load_mem2",   3'd3, 4'h0,    M_MEMREQ | M_MEMSRC);
    cyc(1, "load_mem3",   3'd3, 4'h0,    M_MEMREQ | M_MEMSRC);
    cyc(0, "load_wb",     3'd4, 4'h0,    M_REGWE | M_WBSRC | M_PCEN);

    // STR: pcEn on the ready MEM cycle, no WB
    instr(4'b0100, 4'b0100);
    cyc(1, "str_fetch",  3'd0, 4'h0,    M_MEMREQ | M_IREN);
    cyc(0, "str_decode", 3'd1, 4'h0,    19'd0);
    cyc(0, "str_ex",     3'd2, 4'b0101, 19'd0);
    cyc(1, "str_mem",    3'd3, 4'h0,    M_MEMREQ | M_MEMSRC | M_MEMWR | M_PCEN);

    // CMPI: mem_ready in DECODE must be ignored; 3 cycles total
    instr(4'b1011, 4'b0000);
    cyc(1, "cmpi_fetch",  3'd0, 4'h0,    M_MEMREQ | M_IREN);
    cyc(1, "cmpi_decode", 3'd1, 4'h0,    19'd0);
    cyc(1, "cmpi_ex",     3'd2, 4'b1011, M_ALUSRCB | M_LZN | M_WBPSR | M_PCEN);

    // JAL
    instr(4'b1111, 4'b0000);
    cyc(1, "jal_fetch",  3'd0, 4'h0, M_MEMREQ | M_IREN);
    cyc(0, "jal_decode", 3'd1, 4'h0, 19'd0);
    cyc(0, "jal_ex",     3'd2, 4'h0, M_JUMP | M_RAWRITE | M_PCEN);

    // Illegal opcode 1010
    instr(4'b1010, 4'b0000);
    cyc(1, "ill_fetch",  3'd0, 4'h0, M_MEMREQ | M_IREN);
    cyc(0, "ill_decode", 3'd1, 4'h0, 19'd0);
    cyc(0, "ill_ex",     3'd2, 4'h0, M_ILL | M_PCEN);

    // ASHI (RTYPE2, funct 001x)
    instr(4'b1000, 4'b0011);
    cyc(1, "ashi_fetch",  3'd0, 4'h0, M_MEMREQ | M_IREN);
    cyc(0, "ashi_decode", 3'd1, 4'h0, 19'd0);
    cyc(0, "ashi_ex",     3'd2, 4'h0, M_SHSRC | M_SHTYPE);
    cyc(0, "ashi_wb",     3'd4, 4'h0, M_REGWE | M_PCEN);

    // STR interrupted by reset between edges while in MEM
    instr(4'b0100, 4'b0100);
    cyc(1, "str2_fetch",  3'd0, 4'h0,    M_MEMREQ | M_IREN);
    cyc(0, "str2_decode", 3'd1, 4'h0,    19'd0);
    cyc(0, "str2_ex",     3'd2, 4'b0101, 19'd0);
    cyc(0, "str2_mem",    3'd3, 4'h0,    M_MEMREQ | M_MEMSRC | M_MEMWR);
    reset_n = 1'b0;
    cyc(0, "rst_mid_mem", 3'd0, 4'h0, 19'd0);
    cyc(1, "rst_hold",    3'd0, 4'h0, 19'd0);
    reset_n = 1'b1;
    instr(4'b0000, 4'b0101);
    cyc(1, "post_rst_fetch",  3'd0, 4'h0,    M_MEMREQ | M_IREN);
    cyc(0, "post_rst_decode", 3'd1, 4'h0,    19'd0);
    cyc(0, "post_rst_ex",     3'd2, 4'b0101, M_CF | M_WBPSR);
    cyc(0, "post_rst_wb",     3'd4, 4'h0,    M_REGWE | M_PCEN);
    cyc(0, "final_fetch",     3'd0, 4'h0,    M_MEMREQ);

    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_logic_controller.md
Name: multicycle_logic_controller

Overview:
- Parametrised multicycle control FSM for the 16-bit CR16-style core. Generalises the single-cycle EX/MEM decoder to a FETCH/DECODE/EX/MEM/WB sequencer.
- Adds a memory ready/request handshake and a multi-cycle multiply hold.
- Flags illegal instructions.
- Drives all datapath enables and muxes; the condition check for a branch is evaluated in the datapath.

Parameters:
- OPBITS, 4, opcode width
- FUNCTBITS, 4, function-code width; also the aluop width
- MULT_LATENCY, 3, EX cycles held for MULT/MULTI (>=1)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  OPBITS  instruction [15:12]; valid in DECODE
- functionCode  in  FUNCTBITS  instruction [7:4]; valid in DECODE
- mem_ready  in  1  memory completes the current request this cycle
- memReq  out  1  memory request (instruction fetch or data access)
- irEn  out  1  instruction register load
- pcEn  out  1  PC update; exactly one pulse per instruction
- branch, jump, jumpRA, raWrite  out  1 each  PC-source / link controls
- CFWrite, LZNWrite, wbPSR  out  1 each  flag writes
- RtSrcReg, wbSrc, memSrc, shiftSrc, aluSrcb, shiftType  out  1 each  datapath muxes
- regWriteEn, memWrite  out  1 each  write enables
- aluop  out  FUNCTBITS  ALU operation
- illegal  out  1  one-cycle pulse on an undefined encoding
- state_dbg  out  3  current state

Behaviour:
- Reset:
  - reset_n low forces state FETCH asynchronously and clears the multiply counter, the latched opcode/function and all outputs.
  - After release, the first edge sees FETCH, and memReq is 1 in that cycle.
- States: FETCH=0, DECODE=1, EX=2, MEM=3, WB=4. Codes 5-7 go to FETCH on the next edge.
- Output style: outputs are Moore, decoded from state and the latched opcode/function. Every output is 0 unless listed below.
- FETCH:
  - memReq=1.
  - With mem_ready=1: irEn=1, go to DECODE. Otherwise stay (no timeout).
- DECODE:
  - Latch opcode and functionCode, then go to EX.
  - Encodings:
    - Opcode classes: RTYPE=0000, RTYPE2=1000, MEMTYPE=0100.
    - RTYPE functions: ADD 0101, ADDU 0110, SUB 1001, MULT 1110, CMP 1011, AND 0001, OR 0010, XOR 0011, NOT 0100.
    - RTYPE2 functions: LSH 0100, LSHI 000x, ASH 0110, ASHI 001x.
    - MEMTYPE functions: LOAD 0000, STR 0100, SCOND 1101, J 1100.
    - I-type opcodes: ADDI 0101, SUBI 1001, MULTI 1110, CMPI 1011, ANDI 0001, ORI 0010, XORI 0011, BCOND 1100.
    - Jump opcodes: JAL 1111, JRA 0111.
    - Any other combination is illegal.
- EX, field settings:
  - aluop = latched function for RTYPE; latched opcode for I-type; 0101 for LOAD/STR.
  - aluSrcb=1 for I-type.
  - shiftSrc=1 for RTYPE2; shiftType=1 for ASH/ASHI; RtSrcReg=1 for LSH/ASH.
  - CFWrite=1 for ADD/ADDI/SUB/SUBI/ADDU.
  - LZNWrite=1 for CMP/CMPI/SUB/SUBI.
  - wbPSR = CFWrite | LZNWrite.
- EX, multiply hold:
  - MULT/MULTI stay in EX for exactly MULT_LATENCY cycles, counted by an internal counter.
  - Flag writes are asserted only in the final EX cycle.
- EX, exit rules:
  - LOAD/STR: go to MEM.
  - CMP/CMPI, BCOND, J, JRA, JAL, SCOND: final cycle, then FETCH.
    - BCOND: branch=1.
    - J: jump=1.
    - JRA: jumpRA=1.
    - JAL: jump=1, raWrite=1.
    - SCOND: regWriteEn=1, wbSrc=0.
  - Illegal: illegal=1, pcEn=1, no writes, then FETCH.
  - All others: go to WB.
- MEM:
  - memReq=1, memSrc=1, memWrite=1 for STR.
  - Hold all outputs stable until mem_ready=1.
  - On ready: LOAD goes to WB; STR issues pcEn=1 and goes to FETCH.
- WB:
  - regWriteEn=1, wbSrc=1 for LOAD (0 for ALU/shift results), pcEn=1, then FETCH.
- PC rule: pcEn is asserted only in the last cycle of each instruction, never twice per instruction.
- Reset mid-operation (e.g. in MEM with memWrite=1): memWrite and memReq drop immediately, with no clock edge needed.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- ADD (op 0000, fn 0101), mem_ready=1 in FETCH -> states 0,1,2,4,0; CFWrite=1 and aluop=0101 in EX; regWriteEn=1 and pcEn=1 in WB; 4 cycles total.
- MULTI (op 1110), MULT_LATENCY=3 -> EX held 3 cycles, aluop=1110, aluSrcb=1; WB then FETCH; pcEn pulses once.
- LOAD (0100/0000) with mem_ready low for 2 MEM cycles -> memReq=1 held 3 MEM cycles; WB with wbSrc=1 and regWriteEn=1. STR -> memWrite=1 in MEM, no WB, pcEn on the ready cycle.
- CMPI (1011) -> LZNWrite=1, wbPSR=1, regWriteEn=0; back to FETCH after EX; 3 cycles total.
- JAL (1111) -> jump=1, raWrite=1, pcEn=1 in EX. Illegal op 1010 -> illegal=1 for one cycle, then FETCH.
- reset_n asserted in MEM during STR, between edges -> memWrite=0 and state_dbg=0 immediately; after release, the first cycle has memReq=1 in FETCH.
